// File: rtl/reel_pkg.sv
// Shared types and default geometry for the reel bitmap strip and its scroll reader.
package reel_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ACCEL = 3'd1,
      SPIN  = 3'd2,
      DECEL = 3'd3,
      ALIGN = 3'd4
   } reel_state_e;

   localparam int DEF_REEL_W = 64;
   localparam int DEF_REEL_H = 1024;
   localparam int DEF_SYM_H  = 64;
   localparam int DEF_NSYM   = DEF_REEL_H / DEF_SYM_H;
   localparam int DEF_X0     = 288;
   localparam int DEF_Y0     = 144;
   localparam int DEF_WIN_H  = 192;

   localparam int DEF_XW = $clog2(DEF_REEL_W);
   localparam int DEF_YW = $clog2(DEF_REEL_H);
   localparam int DEF_SW = $clog2(DEF_SYM_H);
   localparam int DEF_NW = $clog2(DEF_NSYM);

endpackage

// File: rtl/reel_motion_fsm.sv
// Spin motion controller: advances the scroll offset once per frame through
// accelerate / spin / decelerate / snap phases and reports the landed symbol.
module reel_motion_fsm
   import reel_pkg::*;
#(
   parameter int REEL_H    = DEF_REEL_H,
   parameter int SYM_H     = DEF_SYM_H,
   parameter int MAX_SPEED = 16,
   parameter int MIN_SPEED = 2
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic                                 frame_tick,
   input  logic                                 start,
   input  logic                                 stop_req,
   output logic [$clog2(REEL_H)-1:0]            offset,
   output logic                                 busy,
   output logic                                 done,
   output logic [$clog2(REEL_H/SYM_H)-1:0]      symbol_idx
);

   localparam int YW  = $clog2(REEL_H);
   localparam int SW  = $clog2(SYM_H);
   localparam int NW  = YW - SW;
   localparam int SPW = $clog2(MAX_SPEED + 1);

   localparam logic [SPW-1:0] ONE_S = SPW'(1);
   localparam logic [SPW-1:0] MAX_S = SPW'(MAX_SPEED);
   localparam logic [SPW-1:0] MIN_S = SPW'(MIN_SPEED);
   localparam logic [SW:0]    SYM_R = (SW+1)'(SYM_H);
   localparam logic [SW:0]    MIN_R = (SW+1)'(MIN_SPEED);

   reel_state_e     state_q, state_d;
   logic [YW-1:0]   offset_q, offset_d;
   logic [SPW-1:0]  speed_q, speed_d;
   logic            stop_pend_q, stop_pend_d;
   logic            done_q, done_d;
   logic [NW-1:0]   symbol_idx_q, symbol_idx_d;

   logic [SW-1:0]   mis;
   logic [SW:0]     rem;
   logic [SW:0]     snap_step;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         offset_q     <= '0;
         speed_q      <= '0;
         stop_pend_q  <= 1'b0;
         done_q       <= 1'b0;
         symbol_idx_q <= '0;
      end else begin
         state_q      <= state_d;
         offset_q     <= offset_d;
         speed_q      <= speed_d;
         stop_pend_q  <= stop_pend_d;
         done_q       <= done_d;
         symbol_idx_q <= symbol_idx_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      offset_d     = offset_q;
      speed_d      = speed_q;
      stop_pend_d  = stop_pend_q;
      done_d       = 1'b0;
      symbol_idx_d = symbol_idx_q;

      // Distance to the next symbol boundary; snapping never overshoots it.
      mis       = offset_q[SW-1:0];
      rem       = SYM_R - {1'b0, mis};
      snap_step = (rem < MIN_R) ? rem : MIN_R;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = ACCEL;
               speed_d     = ONE_S;
               stop_pend_d = 1'b0;
            end
         end
         ACCEL: begin
            if (stop_req) stop_pend_d = 1'b1;
            if (frame_tick) begin
               offset_d = offset_q + YW'(speed_q);
               speed_d  = speed_q + ONE_S;
               if (speed_q + ONE_S == MAX_S) state_d = SPIN;
            end
         end
         SPIN: begin
            if (stop_req) stop_pend_d = 1'b1;
            if (frame_tick) begin
               offset_d = offset_q + YW'(MAX_S);
               if (stop_pend_q) begin
                  state_d     = DECEL;
                  stop_pend_d = 1'b0;
               end
            end
         end
         DECEL: begin
            if (frame_tick) begin
               offset_d = offset_q + YW'(speed_q);
               speed_d  = speed_q - ONE_S;
               if (speed_q - ONE_S == MIN_S) state_d = ALIGN;
            end
         end
         ALIGN: begin
            if (frame_tick) begin
               if (mis == '0) begin
                  state_d      = IDLE;
                  speed_d      = '0;
                  done_d       = 1'b1;
                  symbol_idx_d = offset_q[YW-1:SW] + NW'(1);
               end else begin
                  offset_d = offset_q + YW'(snap_step);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign offset     = offset_q;
   assign busy       = (state_q != IDLE);
   assign done       = done_q;
   assign symbol_idx = symbol_idx_q;

endmodule

// File: rtl/reel_scroll_reader.sv
// Reel RAM read client: maps the VGA pixel inside the reel window to a strip
// address shifted by the scroll offset, and realigns the RAM data to the pixel.
module reel_scroll_reader
   import reel_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 4,
   parameter int REEL_W     = DEF_REEL_W,
   parameter int REEL_H     = DEF_REEL_H,
   parameter int SYM_H      = DEF_SYM_H,
   parameter int WIN_H      = DEF_WIN_H,
   parameter int X0         = DEF_X0,
   parameter int Y0         = DEF_Y0,
   parameter int MAX_SPEED  = 16,
   parameter int MIN_SPEED  = 2
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic [10:0]                          x,
   input  logic [10:0]                          y,
   input  logic                                 frame_tick,
   input  logic                                 start,
   input  logic                                 stop_req,
   output logic [ADDR_WIDTH-1:0]                addr_r,
   input  logic [DATA_WIDTH-1:0]                ram_dout,
   output logic [DATA_WIDTH-1:0]                reel_rgb,
   output logic                                 reel_en,
   output logic                                 busy,
   output logic                                 done,
   output logic [$clog2(REEL_H/SYM_H)-1:0]      symbol_idx
);

   localparam int XW = $clog2(REEL_W);
   localparam int YW = $clog2(REEL_H);

   localparam logic [10:0] X_LO = 11'(X0);
   localparam logic [10:0] X_HI = 11'(X0 + REEL_W);
   localparam logic [10:0] Y_LO = 11'(Y0);
   localparam logic [10:0] Y_HI = 11'(Y0 + WIN_H);

   logic [YW-1:0] offset;
   logic          win_d, win_q;
   logic [XW-1:0] col;
   logic [YW-1:0] row;

   reel_motion_fsm #(
      .REEL_H    (REEL_H),
      .SYM_H     (SYM_H),
      .MAX_SPEED (MAX_SPEED),
      .MIN_SPEED (MIN_SPEED)
   ) u_motion (
      .clk        (clk),
      .reset_n    (reset_n),
      .frame_tick (frame_tick),
      .start      (start),
      .stop_req   (stop_req),
      .offset     (offset),
      .busy       (busy),
      .done       (done),
      .symbol_idx (symbol_idx)
   );

   // Row arithmetic is kept at strip-height width so the scroll wraps for free.
   always_comb begin
      win_d  = (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI);
      col    = x[XW-1:0] - X_LO[XW-1:0];
      row    = y[YW-1:0] - Y_LO[YW-1:0] + offset;
      addr_r = win_d ? ADDR_WIDTH'({row, col}) : '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) win_q <= 1'b0;
      else          win_q <= win_d;
   end

   assign reel_en  = win_q;
   assign reel_rgb = win_q ? ram_dout : '0;

endmodule

// File: tb/tb_reel_scroll_reader.sv
// Directed bench for reel_scroll_reader: address mapping, wrap, full spin cycle, async reset.
module tb_reel_scroll_reader;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [10:0] x = 11'd0;
   logic [10:0] y = 11'd0;
   logic        frame_tick = 1'b0;
   logic        start = 1'b0;
   logic        stop_req = 1'b0;
   logic [15:0] addr_r;
   logic [3:0]  ram_dout = 4'd0;
   logic [3:0]  reel_rgb;
   logic        reel_en;
   logic        busy;
   logic        done;
   logic [3:0]  symbol_idx;

   int n_cmp = 0;
   int n_err = 0;

   reel_scroll_reader dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .x          (x),
      .y          (y),
      .frame_tick (frame_tick),
      .start      (start),
      .stop_req   (stop_req),
      .addr_r     (addr_r),
      .ram_dout   (ram_dout),
      .reel_rgb   (reel_rgb),
      .reel_en    (reel_en),
      .busy       (busy),
      .done       (done),
      .symbol_idx (symbol_idx)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] rom(input logic [15:0] a);
      return a[3:0] ^ a[13:10] ^ 4'hA;
   endfunction

   // Reel RAM model with one-cycle read latency
   always @(posedge clk) ram_dout <= rom(addr_r);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic t, input logic s, input logic p);
      frame_tick = t;
      start      = s;
      stop_req   = p;
      step();
      frame_tick = 1'b0;
      start      = 1'b0;
      stop_req   = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) pulse(1'b1, 1'b0, 1'b0);
   endtask

   task automatic pix(input string tag, input int xi, input int yi, input int ea, input bit ein);
      x = 11'(xi);
      y = 11'(yi);
      #1;
      chk({tag, "_addr"}, addr_r, ea);
      step();
      chk({tag, "_en"}, reel_en, ein);
      chk({tag, "_rgb"}, reel_rgb, ein ? rom(16'(ea)) : 4'd0);
      $display("pix %s x=%0d y=%0d addr=%0d en=%0d rgb=%0d", tag, xi, yi, addr_r, reel_en, reel_rgb);
   endtask

   initial begin
      x = 11'd288;
      y = 11'd144;
      step();
      step();
      chk("rst_addr", addr_r, 0);
      chk("rst_en", reel_en, 0);
      chk("rst_rgb", reel_rgb, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sym", symbol_idx, 0);
      reset_n = 1'b1;
      step();

      // Offset 0: mapping, corners and outside columns/rows
      pix("o0_origin", 288, 144, 0, 1);
      pix("o0_inner", 290, 147, 194, 1);
      pix("o0_xout", 352, 147, 0, 0);
      pix("o0_corner", 351, 335, 12287, 1);
      pix("o0_yout", 300, 336, 0, 0);
      pix("o0_xlow", 287, 150, 0, 0);

      // stop_req in IDLE is ignored
      pulse(1'b0, 1'b0, 1'b1);
      ticks(1);
      chk("idle_stop_busy", busy, 0);
      pix("idle_stop", 290, 147, 194, 1);

      // start with frame_tick: transition only
      pulse(1'b1, 1'b1, 1'b0);
      chk("start_busy", busy, 1);
      pix("start_nomove", 288, 144, 0, 1);

      ticks(2);
      pix("accel_o3", 290, 147, 386, 1);
      ticks(13);
      pix("spin_o120", 288, 144, 7680, 1);
      chk("spin_busy", busy, 1);

      // start during SPIN is ignored; next tick adds 16
      pulse(1'b0, 1'b1, 1'b0);
      ticks(1);
      pix("spin_o136", 288, 144, 8704, 1);

      ticks(55);
      pix("wrap_top", 288, 154, 128, 1);
      pix("wrap_bot", 351, 335, 11775, 1);

      // Stop: spin tick to offset 8, 14 decel ticks to 141, 26 snap ticks to 192
      pulse(1'b0, 1'b0, 1'b1);
      ticks(1);
      pix("decel_o8", 288, 144, 512, 1);
      ticks(14);
      pix("align_o141", 288, 144, 9024, 1);
      ticks(26);
      pix("align_o192", 288, 144, 12288, 1);
      chk("align_busy", busy, 1);
      chk("align_nodone", done, 0);
      ticks(1);
      chk("land_done", done, 1);
      chk("land_busy", busy, 0);
      chk("land_sym", symbol_idx, 4);
      $display("land done=%0d busy=%0d symbol_idx=%0d", done, busy, symbol_idx);
      step();
      chk("land_done_pulse", done, 0);
      chk("land_sym_hold", symbol_idx, 4);

      // Stop during ACCEL acts on first SPIN tick: 192+120+16+16+15 = 359
      pulse(1'b0, 1'b1, 1'b0);
      ticks(5);
      pulse(1'b0, 1'b0, 1'b1);
      ticks(10);
      ticks(1);
      ticks(2);
      pix("decel_o359", 290, 147, 23170, 1);
      chk("decel_busy", busy, 1);

      // Asynchronous reset between clock edges
      #3;
      reset_n = 1'b0;
      #1;
      chk("arst_addr", addr_r, 194);
      chk("arst_en", reel_en, 0);
      chk("arst_rgb", reel_rgb, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_sym", symbol_idx, 0);
      $display("async reset addr=%0d en=%0d busy=%0d sym=%0d", addr_r, reel_en, busy, symbol_idx);
      step();
      reset_n = 1'b1;
      step();
      pix("post_rst", 290, 147, 194, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
